// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, FSM state encoding and instruction buffer entry type
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FULL  = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular instruction buffer; flush wins over push/pop
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t data,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr, wr_ptr;
    fetch_entry_t mem [DEPTH];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with 1-cycle memory, redirect flush
// and a small decoupling buffer toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t state, state_next;
    logic [31:0] pc, inflight_pc;
    logic inflight, pop, push, credit_ok;
    logic [CW-1:0] count;
    logic [CW:0] occ;
    fetch_entry_t head;

    // Credit counts buffered words plus the outstanding response, minus this cycle's pop.
    always_comb begin
        if_valid = (count != '0) && !redirect_i;
        pop = if_valid && id_ready;
        push = inflight && !redirect_i;
        occ = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
        credit_ok = occ < (CW + 1)'(DEPTH);
        imem_req = !rst && !redirect_i && (state != REDIR) && credit_ok;
        state_next = redirect_i ? REDIR : (state == REDIR) ? RUN : credit_ok ? RUN : FULL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc <= RESET_PC;
            inflight <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state <= state_next;
            inflight <= imem_req;
            if (imem_req)
                inflight_pc <= pc;
            pc <= redirect_i ? {redirect_pc_i[31:2], 2'b00} : imem_req ? pc + 32'd4 : pc;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_i),
        .push(push),
        .data('{pc: inflight_pc, instr: imem_rdata}),
        .pop(pop),
        .count(count),
        .head(head)
    );

    assign imem_addr = pc;
    assign if_instr = if_valid ? head.instr : '0;
    assign if_pc = if_valid ? head.pc : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a delivery scoreboard and a request-address model
module tb_fetch_unit;
    localparam logic [31:0] MAGIC = 32'h5A5A_C3C3;

    logic clk = 1'b0, rst = 1'b1, redirect = 1'b0, id_ready = 1'b1;
    logic [31:0] redirect_pc = '0, rdata = '0, w_rdata = '0;
    logic req, valid, w_req, w_valid;
    logic [31:0] addr, instr, pc, w_addr, w_instr, w_pc;
    int checks = 0, errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] base = '0;
    int n = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata <= addr ^ MAGIC;
        w_rdata <= w_addr ^ MAGIC;
    end

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_rdata(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .if_valid(valid),
        .if_instr(instr), .if_pc(pc), .id_ready(id_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect_i(1'b0), .redirect_pc_i(32'h0), .if_valid(w_valid),
        .if_instr(w_instr), .if_pc(w_pc), .id_ready(1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input logic [31:0] start, input int cnt);
        for (int i = 0; i < cnt; i++)
            exp_q.push_back(start + 32'(4 * i));
    endtask

    // Monitor: request addresses follow the reset/redirect base; deliveries pop the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            base = 32'h0;
            n = 0;
        end else if (redirect) begin
            base = {redirect_pc[31:2], 2'b00};
            n = 0;
        end else if (req) begin
            check("req_addr", addr, base + 32'(4 * n));
            n++;
        end
        if (valid && id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver_extra actual_pc=%h required=none", pc);
            end else begin
                e = exp_q.pop_front();
                check("if_pc", pc, e);
                check("if_instr", instr, e ^ MAGIC);
            end
        end
    end

    initial begin
        @(negedge clk);
        check("rst_req", 32'(req), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        step();
        rst = 1'b0;
        expect_run(32'h0, 6);
        @(negedge clk);
        check("c0_req", 32'(req), 32'h1);
        check("c0_addr", addr, 32'h0);
        check("c0_valid", 32'(valid), 32'h0);
        check("wrap0", w_addr, 32'hFFFF_FFF8);
        check("wrap0_req", 32'(w_req), 32'h1);
        step();
        @(negedge clk);
        check("c1_addr", addr, 32'h4);
        check("wrap1", w_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("c2_valid", 32'(valid), 32'h1);
        check("c2_pc", pc, 32'h0);
        check("c2_addr", addr, 32'h8);
        check("wrap2", w_addr, 32'h0000_0000);
        check("wrap2_req", 32'(w_req), 32'h1);
        repeat (5) step();
        step();
        rst = 1'b1;
        id_ready = 1'b0;
        @(negedge clk);
        check("midrst_req", 32'(req), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("bp0_addr", addr, 32'h0);
        check("bp0_req", 32'(req), 32'h1);
        step();
        @(negedge clk);
        check("bp1_addr", addr, 32'h4);
        check("bp1_req", 32'(req), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("bp_req_off", 32'(req), 32'h0);
            check("bp_valid", 32'(valid), 32'h1);
            check("bp_pc_hold", pc, 32'h0);
            check("bp_instr_hold", instr, 32'h0 ^ MAGIC);
        end
        step();
        id_ready = 1'b1;
        expect_run(32'h0, 5);
        repeat (4) step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        check("redir_valid", 32'(valid), 32'h0);
        check("redir_req", 32'(req), 32'h0);
        check("redir_q_empty", 32'(exp_q.size()), 32'h0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("bubble_req", 32'(req), 32'h0);
        check("bubble_valid", 32'(valid), 32'h0);
        step();
        @(negedge clk);
        check("target_req", 32'(req), 32'h1);
        check("target_addr", addr, 32'h0000_0100);
        expect_run(32'h0000_0100, 5);
        repeat (7) step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("redir2_valid", 32'(valid), 32'h0);
        step();
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        check("reredir_req", 32'(req), 32'h0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("reredir_bubble", 32'(req), 32'h0);
        step();
        @(negedge clk);
        check("reredir_addr", addr, 32'h0000_0300);
        check("reredir_req1", 32'(req), 32'h1);
        expect_run(32'h0000_0300, 2);
        repeat (4) step();
        id_ready = 1'b0;
        step();
        @(negedge clk);
        check("full_valid", 32'(valid), 32'h1);
        check("full_pc", pc, 32'h0000_0308);
        check("full_req", 32'(req), 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("fullrst_valid", 32'(valid), 32'h0);
        check("fullrst_req", 32'(req), 32'h0);
        check("fullrst_pc", pc, 32'h0);
        step();
        rst = 1'b0;
        id_ready = 1'b1;
        expect_run(32'h0, 3);
        @(negedge clk);
        check("restart_addr", addr, 32'h0);
        check("restart_req", 32'(req), 32'h1);
        repeat (4) step();
        step();
        id_ready = 1'b0;
        step();
        @(negedge clk);
        check("final_q_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
